adpll_lock_detect: RTL
======================

# adpll_lock_detect

Lock detector for the ADPLL, sitting downstream of the loop filter alongside the VCO. It consumes the 4-bit filter code driving the VCO, the 2.5 kHz reference and the divided feedback clock. It declares lock once the code has been stable for a programmable number of reference periods, with feedback activity present. It reports lock, loss-of-lock and reference loss to the top level.

## Interface
- CODE_W, 4: width of loop-filter code
- STABLE_CNT, 16: consecutive good reference periods required to declare lock (2..255)
- TOL, 1: max allowed absolute code change between consecutive reference periods
- LOSS_CNT, 4: consecutive bad periods in HOLD before lock is dropped (1..255)
- SYNC_STAGES, 2: synchronizer depth for ref_in/fb_in (>=2)
- TIMEOUT, 30000: clk cycles without a reference edge before ref_lost (<2^16)

- clk  in  1  system clock (the 50 MHz vco_clk domain)
- reset  in  1  synchronous, active-high reset
- ref_in  in  1  asynchronous reference clock (clk2_5k)
- fb_in  in  1  asynchronous divided feedback (freq_div output)
- code_in  in  CODE_W  loop-filter output code, unsigned 0..15, driven in clk domain
- locked  out  1  lock indication
- lock_state  out  2  FSM state: 0 UNLOCK, 1 ACQ, 2 LOCK, 3 HOLD
- lol_pulse  out  1  one-cycle pulse on any LOCK/HOLD -> UNLOCK transition
- ref_lost  out  1  reference watchdog expired
- code_hold  out  CODE_W  code sampled at last good event while in LOCK

## Operation
- ref_in and fb_in each pass through SYNC_STAGES flops. A rising edge is detected on the last two stages, producing ref_ev/fb_ev single-cycle strobes.
- fb_seen is set by fb_ev and cleared by each ref_ev. An fb_ev in the same cycle as ref_ev counts toward the closing window.
- On ref_ev, code_in is sampled into prev_code. The event is evaluated against the previous prev_code.
- good = (|code_in - prev_code| <= TOL, computed unsigned in CODE_W+1 bits, no wrap: 0 vs 15 is diff 15) AND fb_seen.
- Priming: the first ref_ev after reset or after ref_lost only loads prev_code. It is not evaluated and the state stays UNLOCK.
- FSM transitions happen only on evaluated ref_ev or watchdog expiry:
  - UNLOCK: good -> ACQ, good_cnt=1; bad -> stay.
  - ACQ: good -> good_cnt+1, and when it reaches STABLE_CNT -> LOCK; bad -> UNLOCK, good_cnt=0.
  - LOCK: good -> stay, code_hold<=code_in; bad -> HOLD, bad_cnt=1.
  - HOLD: good -> LOCK, bad_cnt=0; bad -> bad_cnt+1, and when it reaches LOSS_CNT -> UNLOCK.
- locked = 1 in LOCK and HOLD, 0 otherwise, registered from the FSM state.
- Watchdog: a 16-bit counter is cleared on ref_ev and otherwise increments, saturating.
  - When it reaches TIMEOUT: ref_lost<=1, FSM -> UNLOCK, counters cleared, prime flag re-armed.
  - Reaching TIMEOUT from LOCK or HOLD also asserts lol_pulse.
- ref_lost clears on the next ref_ev, which is a priming event.

## Timing
- Reset values: locked=0, lock_state=0, lol_pulse=0, ref_lost=0, code_hold=0, all counters 0, sync flops 0, prime armed.
- Pin-to-ref_ev latency: SYNC_STAGES+1 clk cycles. FSM outputs update on the clock edge after ref_ev, for a total of SYNC_STAGES+2 cycles from the ref_in rising edge.
- lol_pulse is high exactly one cycle, coincident with lock_state becoming 0.
- reset asserted mid-operation returns all state to reset values on the next clk edge, regardless of ref/fb activity. The next ref edge is a priming event.
- Watchdog expiry and ref_ev in the same cycle: ref_ev wins, the counter clears and no ref_lost is raised.
- code_in is sampled in the same cycle as ref_ev, with no extra synchronization: it is already in the clk domain.

## Configuration
- LOCK_DET_FB_CHECK_EN defined: good requires fb_seen, as above.
- Undefined: fb_in is ignored (the port stays, its synchronizer and fb_seen logic are removed), and good depends only on code stability.

## Test plan
- Reset, then 20 ref periods (20000 clk each) with code_in=8 and fb toggling -> ACQ after the 2nd ref edge; locked=1 exactly after the 17th ref edge (16 good); code_hold=8.
- Locked, then code_in alternates 8/10 (diff 2 > TOL) -> HOLD after the 1st bad event; after the 4th bad event lock_state=0, locked=0, one-cycle lol_pulse.
- Locked, one bad event (code jumps to 12) then code stays 12 -> HOLD, then back to LOCK on the next event; locked never drops; code_hold=12.
- Locked, ref_in stopped -> ref_lost=1, lock_state=0 and lol_pulse exactly TIMEOUT cycles after the last ref_ev; on ref restart, ref_lost clears and STABLE_CNT+1 edges are needed to relock.
- With LOCK_DET_FB_CHECK_EN, fb_in held low and code constant -> never leaves UNLOCK; without the macro, same stimulus locks after 17 edges.
- Assert reset for 1 cycle while in HOLD -> all outputs 0 on the next cycle, no lol_pulse; ref_edge and fb_edge in the same cycle are counted as fb_seen.

Source files
------------

// File: rtl/adpll_lock_detect.sv
// adpll_lock_detect
// Lock detector for the ADPLL. Watches the loop-filter code on each
// reference edge and declares lock once the code has been stable for
// STABLE_CNT reference periods. Reports loss of lock and reference loss.
// Optional feature: define LOCK_DET_FB_CHECK_EN to also require a divided
// feedback edge inside every reference period. When it is undefined, fb_in
// is ignored.
module adpll_lock_detect #(
    parameter int CODE_W      = 4,
    parameter int STABLE_CNT  = 16,
    parameter int TOL         = 1,
    parameter int LOSS_CNT    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 30000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ref_in,
    input  logic              fb_in,
    input  logic [CODE_W-1:0] code_in,
    output logic              locked,
    output logic [1:0]        lock_state,
    output logic              lol_pulse,
    output logic              ref_lost,
    output logic [CODE_W-1:0] code_hold
);

    localparam logic [1:0] ST_UNLOCK = 2'd0;
    localparam logic [1:0] ST_ACQ    = 2'd1;
    localparam logic [1:0] ST_LOCK   = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    localparam logic [CODE_W:0] TOL_V    = (CODE_W+1)'(TOL);
    localparam logic [7:0]      STABLE_V = 8'(STABLE_CNT);
    localparam logic [7:0]      LOSS_V   = 8'(LOSS_CNT);
    localparam logic [15:0]     WD_LAST  = 16'(TIMEOUT - 1);

    // Absolute difference of two unsigned codes, no wrap-around.
    function automatic logic [CODE_W:0] code_dist(input logic [CODE_W-1:0] a,
                                                  input logic [CODE_W-1:0] b);
        logic signed [CODE_W+1:0] d;
        d = $signed({2'b00, a}) - $signed({2'b00, b});
        if (d[CODE_W+1]) begin
            d = -d;
        end
        return d[CODE_W:0];
    endfunction

    logic [SYNC_STAGES-1:0] ref_sync;
    logic                   ref_last;
    logic                   ref_ev;
    logic                   fb_ok;

    // Stage 0: synchronize ref_in and register a single-cycle rising-edge strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            ref_sync <= '0;
            ref_last <= 1'b0;
            ref_ev   <= 1'b0;
        end else begin
            ref_sync <= {ref_sync[SYNC_STAGES-2:0], ref_in};
            ref_last <= ref_sync[SYNC_STAGES-1];
            ref_ev   <= ref_sync[SYNC_STAGES-1] & ~ref_last;
        end
    end

`ifdef LOCK_DET_FB_CHECK_EN
    logic [SYNC_STAGES-1:0] fb_sync;
    logic                   fb_last;
    logic                   fb_ev;
    logic                   fb_seen;

    // Stage 0: synchronize fb_in and register its rising-edge strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            fb_sync <= '0;
            fb_last <= 1'b0;
            fb_ev   <= 1'b0;
        end else begin
            fb_sync <= {fb_sync[SYNC_STAGES-2:0], fb_in};
            fb_last <= fb_sync[SYNC_STAGES-1];
            fb_ev   <= fb_sync[SYNC_STAGES-1] & ~fb_last;
        end
    end

    // Remember feedback activity inside the current reference window
    always_ff @(posedge clk) begin
        if (reset) begin
            fb_seen <= 1'b0;
        end else if (ref_ev) begin
            fb_seen <= 1'b0;
        end else if (fb_ev) begin
            fb_seen <= 1'b1;
        end
    end

    // A feedback edge landing together with the closing ref edge still counts
    assign fb_ok = fb_seen | fb_ev;
`else
    logic unused_fb;
    assign unused_fb = fb_in;
    assign fb_ok     = 1'b1;
`endif

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [7:0]        good_cnt;
    logic [7:0]        good_nxt;
    logic [7:0]        bad_cnt;
    logic [7:0]        bad_nxt;
    logic [CODE_W-1:0] prev_code;
    logic [CODE_W-1:0] hold_nxt;
    logic              prime;
    logic              prime_nxt;
    logic              lost_nxt;
    logic              lol_nxt;
    logic [15:0]       wd_cnt;
    logic              wd_expire;
    logic              good;

    assign good       = (code_dist(code_in, prev_code) <= TOL_V) && fb_ok;
    // A ref edge in the expiry cycle wins over the watchdog
    assign wd_expire  = !ref_ev && (wd_cnt == WD_LAST);
    assign lock_state = state;

    // Stage 1: next-state evaluation on ref edges and watchdog expiry
    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        bad_nxt   = bad_cnt;
        hold_nxt  = code_hold;
        prime_nxt = prime;
        lost_nxt  = ref_lost;
        lol_nxt   = 1'b0;
        if (ref_ev) begin
            lost_nxt = 1'b0;
            if (prime) begin
                // First edge only seeds prev_code
                prime_nxt = 1'b0;
            end else begin
                case (state)
                    ST_UNLOCK: begin
                        if (good) begin
                            state_nxt = ST_ACQ;
                            good_nxt  = 8'd1;
                        end
                    end
                    ST_ACQ: begin
                        if (good) begin
                            good_nxt = good_cnt + 8'd1;
                            if (good_nxt >= STABLE_V) begin
                                state_nxt = ST_LOCK;
                            end
                        end else begin
                            state_nxt = ST_UNLOCK;
                            good_nxt  = 8'd0;
                        end
                    end
                    ST_LOCK: begin
                        if (good) begin
                            hold_nxt = code_in;
                        end else begin
                            state_nxt = ST_HOLD;
                            bad_nxt   = 8'd1;
                        end
                    end
                    default: begin
                        if (good) begin
                            state_nxt = ST_LOCK;
                            bad_nxt   = 8'd0;
                        end else begin
                            bad_nxt = bad_cnt + 8'd1;
                            if (bad_nxt >= LOSS_V) begin
                                state_nxt = ST_UNLOCK;
                                bad_nxt   = 8'd0;
                                good_nxt  = 8'd0;
                                lol_nxt   = 1'b1;
                            end
                        end
                    end
                endcase
            end
        end else if (wd_expire) begin
            state_nxt = ST_UNLOCK;
            good_nxt  = 8'd0;
            bad_nxt   = 8'd0;
            prime_nxt = 1'b1;
            lost_nxt  = 1'b1;
            lol_nxt   = state[1];
        end
    end

    // Stage 2: register FSM, counters, watchdog and outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_UNLOCK;
            good_cnt  <= 8'd0;
            bad_cnt   <= 8'd0;
            prev_code <= '0;
            code_hold <= '0;
            prime     <= 1'b1;
            ref_lost  <= 1'b0;
            lol_pulse <= 1'b0;
            locked    <= 1'b0;
            wd_cnt    <= 16'd0;
        end else begin
            state     <= state_nxt;
            good_cnt  <= good_nxt;
            bad_cnt   <= bad_nxt;
            code_hold <= hold_nxt;
            prime     <= prime_nxt;
            ref_lost  <= lost_nxt;
            lol_pulse <= lol_nxt;
            locked    <= state_nxt[1];
            if (ref_ev) begin
                prev_code <= code_in;
                wd_cnt    <= 16'd0;
            end else if (wd_cnt != 16'hFFFF) begin
                wd_cnt <= wd_cnt + 16'd1;
            end
        end
    end

endmodule
